cap_cam_if: RTL

- Camera-side front end of the capture path, running in the PCLK domain.
- Receives the OV7670-style byte stream (VSYNC, HREF, CAMDATA, two bytes per RGB565 pixel) and frames it against the selected resolution.
- Expands each pixel to 24-bit RGB and pushes it, tagged with start-of-frame, into the write port of the capture async FIFO.
- The AXI write master on the ACLK side drains that FIFO into VRAM.

---
 rtl/cap_cam_if_if.sv | 13 +
 rtl/cap_cam_if.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cap_cam_if_if.sv
// cap_cam_if_if: write-side port of the capture async FIFO.
//   FIFO_WR    write strobe, one per accepted pixel
//   FIFO_DATA  {SOF, R[7:0], G[7:0], B[7:0]}
//   FIFO_FULL  FIFO cannot accept a write this cycle
// master = pixel producer (camera front end), slave = FIFO write port.
interface cap_cam_if_if;
  logic        FIFO_WR;
  logic [24:0] FIFO_DATA;
  logic        FIFO_FULL;

  modport master (output FIFO_WR, output FIFO_DATA, input FIFO_FULL);
  modport slave  (input FIFO_WR, input FIFO_DATA, output FIFO_FULL);
endinterface

// File: rtl/cap_cam_if.sv
// cap_cam_if: camera-side capture front end (PCLK domain).
// Frames an OV7670-style RGB565 byte stream against the selected resolution,
// expands each pixel to RGB888 and writes it, tagged with start-of-frame,
// into the capture FIFO.
// Ports:
//   PCLK, PRST        pixel clock, synchronous active-high reset
//   CAPON             capture enable (already in PCLK domain)
//   RESOL[1:0]        00/11 VGA, 01 XGA, 10 SXGA; latched at frame start
//   VSYNC, HREF       camera frame sync / line valid
//   CAMDATA[7:0]      camera byte, two per pixel
//   fifo              FIFO write port (master side)
//   FRAME_DONE        one-cycle pulse after a complete frame
//   CAP_OVER          sticky: pixel dropped on FIFO_FULL
//   CAP_ERR           sticky: framing error
module cap_cam_if #(
  parameter int H_VGA  = 640,
  parameter int V_VGA  = 480,
  parameter int H_XGA  = 1024,
  parameter int V_XGA  = 768,
  parameter int H_SXGA = 1280,
  parameter int V_SXGA = 1024
) (
  input  logic               PCLK,
  input  logic               PRST,
  input  logic               CAPON,
  input  logic [1:0]         RESOL,
  input  logic               VSYNC,
  input  logic               HREF,
  input  logic [7:0]         CAMDATA,
  cap_cam_if_if.master       fifo,
  output logic               FRAME_DONE,
  output logic               CAP_OVER,
  output logic               CAP_ERR
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_VS = 2'd1;
  localparam logic [1:0] ST_ACTIVE  = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [10:0] HM_VGA  = 11'(H_VGA);
  localparam logic [10:0] VM_VGA  = 11'(V_VGA);
  localparam logic [10:0] HM_XGA  = 11'(H_XGA);
  localparam logic [10:0] VM_XGA  = 11'(V_XGA);
  localparam logic [10:0] HM_SXGA = 11'(H_SXGA);
  localparam logic [10:0] VM_SXGA = 11'(V_SXGA);

  // RGB565 split over two bytes, expanded by replicating the top bits.
  function automatic logic [23:0] expand_rgb565(input logic [7:0] hi, input logic [7:0] lo);
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    r5 = hi[7:3];
    g6 = {hi[2:0], lo[7:5]};
    b5 = lo[4:0];
    return {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
  endfunction

  logic        vs_r, vs_d_r, href_r, href_d_r;
  logic [7:0]  data_r, hi_byte_r;
  logic [1:0]  state_r;
  logic [10:0] hmax_r, vmax_r, hcnt_r, vcnt_r;
  logic        phase_r, vs_seen_r, sof_pend_r;
  logic        pix_vld_r;
  logic [24:0] pix_data_r;
  logic        fifo_wr_r, frame_done_r, cap_over_r, cap_err_r;
  logic [24:0] fifo_data_r;

  logic [10:0] hmax_sel_s, vmax_sel_s;
  logic        href_rise_s, href_fall_s, vs_rise_s, cur_phase_s;
  logic        pix_done_s, overrun_s, clr_sticky_s;

  // Resolution decode for the latch points (IDLE exit and DONE).
  always_comb begin
    hmax_sel_s = HM_VGA;
    vmax_sel_s = VM_VGA;
    case (RESOL)
      2'b01:   begin hmax_sel_s = HM_XGA;  vmax_sel_s = VM_XGA;  end
      2'b10:   begin hmax_sel_s = HM_SXGA; vmax_sel_s = VM_SXGA; end
      default: begin hmax_sel_s = HM_VGA;  vmax_sel_s = VM_VGA;  end
    endcase
  end

  assign href_rise_s  = href_r & ~href_d_r;
  assign href_fall_s  = ~href_r & href_d_r;
  assign vs_rise_s    = vs_r & ~vs_d_r;
  // The first byte after an HREF rise is always phase 0, whatever phase_r holds.
  assign cur_phase_s  = href_rise_s ? 1'b0 : phase_r;
  assign pix_done_s   = (state_r == ST_ACTIVE) && href_r && !vs_rise_s && cur_phase_s;
  assign overrun_s    = pix_done_s && (hcnt_r == hmax_r);
  assign clr_sticky_s = (state_r == ST_IDLE) && CAPON;

  // Input stage: single register on every camera input, plus edge-detect copies.
  always_ff @(posedge PCLK) begin
    if (PRST) begin
      vs_r     <= 1'b0;
      vs_d_r   <= 1'b0;
      href_r   <= 1'b0;
      href_d_r <= 1'b0;
      data_r   <= 8'h00;
    end else begin
      vs_r     <= VSYNC;
      vs_d_r   <= vs_r;
      href_r   <= HREF;
      href_d_r <= href_r;
      data_r   <= CAMDATA;
    end
  end

  // Frame FSM, line/pixel counters, byte phase and framing-error flag.
  always_ff @(posedge PCLK) begin
    if (PRST) begin
      state_r    <= ST_IDLE;
      hmax_r     <= 11'd0;
      vmax_r     <= 11'd0;
      hcnt_r     <= 11'd0;
      vcnt_r     <= 11'd0;
      phase_r    <= 1'b0;
      hi_byte_r  <= 8'h00;
      vs_seen_r  <= 1'b0;
      sof_pend_r <= 1'b0;
      cap_err_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (CAPON) begin
            hmax_r    <= hmax_sel_s;
            vmax_r    <= vmax_sel_s;
            vs_seen_r <= 1'b0;
            cap_err_r <= 1'b0;
            state_r   <= ST_WAIT_VS;
          end
        end
        ST_WAIT_VS: begin
          if (!CAPON) begin
            state_r <= ST_IDLE;
          end else if (vs_seen_r && !vs_r) begin
            // vs_seen_r implies VSYNC was high, so low now is the falling edge
            hcnt_r     <= 11'd0;
            vcnt_r     <= 11'd0;
            phase_r    <= 1'b0;
            sof_pend_r <= 1'b1;
            vs_seen_r  <= 1'b0;
            state_r    <= ST_ACTIVE;
          end else if (vs_r) begin
            vs_seen_r <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (vs_rise_s) begin
            // short frame: this pulse also serves as the next frame's VSYNC
            cap_err_r  <= 1'b1;
            vs_seen_r  <= 1'b1;
            sof_pend_r <= 1'b0;
            state_r    <= ST_WAIT_VS;
          end else if (href_fall_s) begin
            if ((hcnt_r != hmax_r) || phase_r) begin
              cap_err_r <= 1'b1;
            end
            vcnt_r  <= vcnt_r + 11'd1;
            hcnt_r  <= 11'd0;
            phase_r <= 1'b0;
            if ((vcnt_r + 11'd1) == vmax_r) begin
              state_r <= ST_DONE;
            end
          end else if (href_r) begin
            if (!cur_phase_s) begin
              hi_byte_r <= data_r;
              phase_r   <= 1'b1;
            end else begin
              phase_r    <= 1'b0;
              sof_pend_r <= 1'b0;
              if (overrun_s) begin
                cap_err_r <= 1'b1;
              end else begin
                hcnt_r <= hcnt_r + 11'd1;
              end
            end
          end
        end
        ST_DONE: begin
          hmax_r    <= hmax_sel_s;
          vmax_r    <= vmax_sel_s;
          vs_seen_r <= 1'b0;
          state_r   <= ST_WAIT_VS;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Pixel stage: holds the assembled, expanded pixel for one cycle.
  always_ff @(posedge PCLK) begin
    if (PRST) begin
      pix_vld_r  <= 1'b0;
      pix_data_r <= 25'd0;
    end else begin
      pix_vld_r <= pix_done_s && !overrun_s;
      if (pix_done_s) begin
        pix_data_r <= {sof_pend_r, expand_rgb565(hi_byte_r, data_r)};
      end
    end
  end

  // Output stage: FIFO write (or drop on full), frame-done pulse, overflow flag.
  always_ff @(posedge PCLK) begin
    if (PRST) begin
      fifo_wr_r    <= 1'b0;
      fifo_data_r  <= 25'd0;
      frame_done_r <= 1'b0;
      cap_over_r   <= 1'b0;
    end else begin
      fifo_wr_r    <= pix_vld_r && !fifo.FIFO_FULL;
      frame_done_r <= (state_r == ST_DONE);
      if (pix_vld_r && !fifo.FIFO_FULL) begin
        fifo_data_r <= pix_data_r;
      end
      if (clr_sticky_s) begin
        cap_over_r <= 1'b0;
      end else if (pix_vld_r && fifo.FIFO_FULL) begin
        cap_over_r <= 1'b1;
      end
    end
  end

  assign fifo.FIFO_WR   = fifo_wr_r;
  assign fifo.FIFO_DATA = fifo_data_r;
  assign FRAME_DONE     = frame_done_r;
  assign CAP_OVER       = cap_over_r;
  assign CAP_ERR        = cap_err_r;

endmodule
